instruction_fetch_unit: RTL and testbench

//  Upstream of the instruction decoder/control stage: holds the 6-bit program counter,

---
 rtl/instruction_fetch_unit.sv | 97 +++++++++
 tb/tb_instruction_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instructions over a req/ack
// handshake and presents each one to the decoder for a single EXEC cycle.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_enable,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instruction_valid,
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   pc_load,
  input  logic [ADDR_WIDTH-1:0]  pc_target,
  input  logic                   resume,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_halted;
  logic [CNT_WIDTH-1:0]   r_count;

  logic                   w_is_halt;
  logic [ADDR_WIDTH-1:0]  w_pc_inc;
  logic                   w_count_sat;

  assign w_is_halt   = (r_instr[INSTR_WIDTH-1 -: 2] == 2'b11);
  assign w_pc_inc    = r_pc + ADDR_WIDTH'(1);
  assign w_count_sat = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_enable) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!w_count_sat) r_count <= r_count + CNT_WIDTH'(1);
          // A halt instruction wins over any redirect the decoder presents.
          if (w_is_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= pc_load ? pc_target : w_pc_inc;
            r_state <= fetch_enable ? S_FETCH : S_IDLE;
          end
        end
        S_HALT: begin
          if (resume) begin
            r_pc     <= w_pc_inc;
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request is decoded from state so an asynchronous reset drops it immediately.
  assign imem_req          = (r_state == S_FETCH);
  assign imem_addr         = r_pc;
  assign instruction       = r_instr;
  assign instruction_valid = (r_state == S_EXEC);
  assign pc                = r_pc;
  assign halted            = r_halted;
  assign retired_count     = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a memory responder with programmable ack
// delay, a scoreboard of expected {pc, instruction} pairs, and a monitor on EXEC cycles.
module tb_instruction_fetch_unit;

  localparam int AW = 6;
  localparam int IW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_enable;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_ack;
  logic [IW-1:0] instruction;
  logic          instruction_valid;
  logic [AW-1:0] pc;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          resume;
  logic          halted;
  logic [CW-1:0] retired_count;

  instruction_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (6'd0),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_enable     (fetch_enable),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ack         (imem_ack),
    .instruction      (instruction),
    .instruction_valid(instruction_valid),
    .pc               (pc),
    .pc_load          (pc_load),
    .pc_target        (pc_target),
    .resume           (resume),
    .halted           (halted),
    .retired_count    (retired_count)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [IW-1:0]    mem [64];
  int               mem_delay = 0;
  bit               mem_auto  = 1'b1;
  logic [AW+IW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [IW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_exec();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (instruction_valid) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_exec: got no instruction_valid expected one within 40 cycles at %0t", $time);
  endtask

  // Memory responder: acks after mem_delay cycles of a held request.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        if (imem_req) begin
          if (cnt >= mem_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            cnt        = 0;
          end else begin
            imem_ack = 1'b0;
            cnt++;
          end
        end else begin
          imem_ack = 1'b0;
          cnt      = 0;
        end
      end
    end
  end

  // Monitor: every EXEC cycle must match the oldest expected {pc, instruction}.
  initial begin
    logic [AW+IW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instruction_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_exec: got pc %h instr %h expected no EXEC at %0t",
                   pc, instruction, $time);
        end else begin
          e = exp_q.pop_front();
          check("exec_pc", 32'(pc), 32'(e[AW+IW-1:IW]));
          check("exec_instr", 32'(instruction), 32'(e[IW-1:0]));
          $display("exec pc=%h instr=%h count=%0d", pc, instruction, retired_count);
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = IW'(i);
    rst_n = 1'b0; fetch_enable = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    pc_load = 1'b0; pc_target = '0; resume = 1'b0;

    // Reset state and zero-wait streaming of words 0..2
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instruction_valid), 0);
    check("rst_instr", 32'(instruction), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", 32'(retired_count), 0);
    push_exp(6'd0, 16'h0000); push_exp(6'd1, 16'h0001); push_exp(6'd2, 16'h0002);
    rst_n = 1'b1;
    begin
      logic [3:0] req_t [1:8]   = '{0, 1, 0, 1, 0, 1, 0, 0};
      logic [3:0] val_t [1:8]   = '{0, 0, 1, 0, 1, 0, 1, 0};
      logic [3:0] cnt_t [1:8]   = '{0, 0, 0, 1, 1, 2, 2, 3};
      logic [3:0] addr_t [1:8]  = '{0, 0, 0, 1, 1, 2, 2, 3};
      for (int k = 1; k <= 8; k++) begin
        if (k > 1) @(negedge clk);
        check($sformatf("t1_req_c%0d", k), 32'(imem_req), 32'(req_t[k]));
        check($sformatf("t1_valid_c%0d", k), 32'(instruction_valid), 32'(val_t[k]));
        check($sformatf("t1_count_c%0d", k), 32'(retired_count), 32'(cnt_t[k]));
        if (req_t[k] == 4'd1) check($sformatf("t1_addr_c%0d", k), 32'(imem_addr), 32'(addr_t[k]));
        if (k == 7) fetch_enable = 1'b0;
      end
      check("t1_idle_pc", 32'(pc), 3);
    end

    // Redirect at pc=4 to 2A, ignored pc_load in FETCH, redirect to 5, slow ack at 5
    push_exp(6'd3, 16'h0003); push_exp(6'd4, 16'h0004); push_exp(6'h2A, 16'h002A);
    push_exp(6'd5, 16'h0005);
    fetch_enable = 1'b1;
    wait_exec();
    wait_exec();
    pc_load = 1'b1; pc_target = 6'h2A;
    @(negedge clk);
    check("t3_redirect_addr", 32'(imem_addr), 32'h2A);
    pc_target = 6'h11;
    wait_exec();
    pc_target = 6'd5;
    mem_delay = 3;
    @(negedge clk);
    pc_load = 1'b0;
    n = 0;
    while (imem_req && n < 20) begin
      check($sformatf("t2_hold_addr_%0d", n), 32'(imem_addr), 5);
      n++;
      @(negedge clk);
    end
    check("t2_req_cycles", 32'(n), 4);
    check("t2_exec_after_wait", 32'(instruction_valid), 1);
    fetch_enable = 1'b0;
    mem_delay = 0;
    @(negedge clk);
    check("t2_pc_after", 32'(pc), 6);
    check("t2_req_idle", 32'(imem_req), 0);

    // Wrap 63 -> 0, then halt at 63 and resume to address 0
    push_exp(6'd6, 16'h0006); push_exp(6'd63, 16'h003F); push_exp(6'd0, 16'h0000);
    fetch_enable = 1'b1;
    wait_exec();
    pc_load = 1'b1; pc_target = 6'd63;
    @(negedge clk);
    pc_load = 1'b0;
    wait_exec();
    @(negedge clk);
    check("t4_wrap_addr", 32'(imem_addr), 0);
    wait_exec();
    fetch_enable = 1'b0;
    mem[63] = 16'hC03F;
    @(negedge clk);
    check("t4_idle_pc", 32'(pc), 1);
    push_exp(6'd1, 16'h0001); push_exp(6'd63, 16'hC03F);
    fetch_enable = 1'b1;
    wait_exec();
    pc_load = 1'b1; pc_target = 6'd63;
    @(negedge clk);
    pc_load = 1'b0;
    wait_exec();
    @(negedge clk);
    check("t4_halted", 32'(halted), 1);
    check("t4_halt_pc", 32'(pc), 63);
    push_exp(6'd0, 16'h0000);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("t4_resume_req", 32'(imem_req), 1);
    check("t4_resume_addr", 32'(imem_addr), 0);
    check("t4_resume_halted", 32'(halted), 0);
    wait_exec();
    fetch_enable = 1'b0;
    mem[63] = 16'h003F;
    @(negedge clk);

    // Halt at 3 with an ignored redirect; stay halted 10 cycles; resume to 4
    push_exp(6'd1, 16'h0001); push_exp(6'd2, 16'h0002); push_exp(6'd3, 16'hC000);
    mem[3] = 16'hC000;
    fetch_enable = 1'b1;
    wait_exec();
    wait_exec();
    wait_exec();
    pc_load = 1'b1; pc_target = 6'h10;
    @(negedge clk);
    pc_load = 1'b0;
    check("t5_halt_pc", 32'(pc), 3);
    check("t5_halt_count", 32'(retired_count), 16);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t5_halted_%0d", i), 32'(halted), 1);
      check($sformatf("t5_req_%0d", i), 32'(imem_req), 0);
      @(negedge clk);
    end
    push_exp(6'd4, 16'h0004);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("t5_resume_addr", 32'(imem_addr), 4);
    check("t5_resume_req", 32'(imem_req), 1);
    check("t5_resume_halted", 32'(halted), 0);
    wait_exec();
    fetch_enable = 1'b0;
    mem[3] = 16'h0003;
    @(negedge clk);
    check("t5_pc_after", 32'(pc), 5);
    check("t5_count", 32'(retired_count), 17);

    // Reset mid-FETCH at 7, then a late ack that must be ignored
    push_exp(6'd5, 16'h0005);
    fetch_enable = 1'b1;
    wait_exec();
    pc_load = 1'b1; pc_target = 6'd7;
    mem_auto = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    pc_load = 1'b0;
    check("t6_fetch_addr", 32'(imem_addr), 7);
    repeat (2) @(negedge clk);
    check("t6_fetch_req", 32'(imem_req), 1);
    rst_n = 1'b0;
    fetch_enable = 1'b0;
    #1;
    check("t6_rst_req", 32'(imem_req), 0);
    check("t6_rst_pc", 32'(pc), 0);
    check("t6_rst_count", 32'(retired_count), 0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'hC0DE;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_late_ack_instr", 32'(instruction), 0);
    check("t6_late_ack_req", 32'(imem_req), 0);
    check("t6_late_ack_valid", 32'(instruction_valid), 0);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
